// File: rtl/shift_pkg.sv
// Shared types for the 8-op shift register and its command sequencer.
//   OP_t        : register operation select (the S bus encoding)
//   seq_state_t : sequencer FSM states
//   SHIFT_W_DEF : default register width
package shift_pkg;

  localparam int unsigned SHIFT_W_DEF = 8;

  typedef enum logic [2:0] {
    NOP    = 3'd0,
    IILOAD = 3'd1,
    LSR    = 3'd2,
    LSL    = 3'd3,
    RR     = 3'd4,
    RL     = 3'd5,
    ASR    = 3'd6,
    ASL    = 3'd7
  } OP_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/shift_reg.sv
// 8-op N-bit shift register driven by shift_seq_ctrl.
// Ports:
//   clk   : clock, rising edge
//   clear : asynchronous active-low reset, Q -> 0
//   S     : operation select (OP_t)
//   D     : parallel load data (used by IILOAD only)
//   MSBin : serial-in for LSR
//   LSBin : serial-in for LSL
//   Q     : register contents
module shift_reg
  import shift_pkg::*;
#(
  parameter int unsigned N = SHIFT_W_DEF
) (
  input  logic         clk,
  input  logic         clear,
  input  OP_t          S,
  input  logic [N-1:0] D,
  input  logic         MSBin,
  input  logic         LSBin,
  output logic [N-1:0] Q
);

  logic [N-1:0] q_q;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q_q <= '0;
    end else begin
      unique case (S)
        NOP:     q_q <= q_q;
        IILOAD:  q_q <= D;
        LSR:     q_q <= {MSBin, q_q[N-1:1]};
        LSL:     q_q <= {q_q[N-2:0], LSBin};
        RR:      q_q <= {q_q[0], q_q[N-1:1]};
        RL:      q_q <= {q_q[N-2:0], q_q[N-1]};
        ASR:     q_q <= {q_q[N-1], q_q[N-1:1]};
        ASL:     q_q <= {q_q[N-2:0], 1'b0};
        default: q_q <= q_q;
      endcase
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for the 8-op shift register. Takes one command per
// valid/ready handshake, loads the register, shifts it cmd_count times and
// returns the final register value with a one-cycle done pulse.
// Ports:
//   clk, clear          : clock; async active-low reset (shared with register)
//   cmd_valid/cmd_ready : command handshake, ready only in IDLE
//   cmd_op/data/count/fill : operation, load value, shift count, serial-in bit
//   S, D, MSBin, LSBin  : register controls (all registered)
//   sr_q                : register Q readback
//   busy                : FSM not idle
//   done, result        : completion pulse and captured sr_q
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int unsigned N  = SHIFT_W_DEF,
  parameter int unsigned CW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  OP_t           cmd_op,
  input  logic [N-1:0]  cmd_data,
  input  logic [CW-1:0] cmd_count,
  input  logic          cmd_fill,
  output OP_t           S,
  output logic [N-1:0]  D,
  output logic          MSBin,
  output logic          LSBin,
  input  logic [N-1:0]  sr_q,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result
);

  seq_state_t    state_q;
  OP_t           op_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] rem_q;
  logic          fill_q;
  OP_t           s_q;
  logic [N-1:0]  d_q;
  logic          msb_q;
  logic          lsb_q;
  logic          done_q;
  logic [N-1:0]  result_q;
  logic          accept;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q  <= ST_IDLE;
      op_q     <= NOP;
      cnt_q    <= '0;
      rem_q    <= '0;
      fill_q   <= 1'b0;
      s_q      <= NOP;
      d_q      <= '0;
      msb_q    <= 1'b0;
      lsb_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= cmd_op;
            cnt_q  <= cmd_count;
            fill_q <= cmd_fill;
            if (cmd_op == NOP) begin
              // NOP never touches the register; just report its current Q.
              state_q <= ST_DONE;
              s_q     <= NOP;
            end else begin
              state_q <= ST_LOAD;
              s_q     <= IILOAD;
              d_q     <= cmd_data;
            end
          end else begin
            s_q <= NOP;
          end
        end
        ST_LOAD: begin
          // The register takes D on this edge; shifting starts on the next.
          if (op_q == IILOAD || cnt_q == '0) begin
            state_q <= ST_DONE;
            s_q     <= NOP;
          end else begin
            state_q <= ST_SHIFT;
            s_q     <= op_q;
            rem_q   <= cnt_q;
            msb_q   <= (op_q == LSR) && fill_q;
            lsb_q   <= (op_q == LSL) && fill_q;
          end
        end
        ST_SHIFT: begin
          rem_q <= rem_q - CW'(1);
          // Last shift happens on this edge; drop controls so the register holds.
          if (rem_q == CW'(1)) begin
            state_q <= ST_DONE;
            s_q     <= NOP;
            msb_q   <= 1'b0;
            lsb_q   <= 1'b0;
          end
        end
        ST_DONE: begin
          state_q  <= ST_IDLE;
          done_q   <= 1'b1;
          result_q <= sr_q;
        end
        default: begin
          state_q <= ST_IDLE;
          s_q     <= NOP;
        end
      endcase
    end
  end

  assign S      = s_q;
  assign D      = d_q;
  assign MSBin  = msb_q;
  assign LSBin  = lsb_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;
  import shift_pkg::*;

  localparam int N  = 8;
  localparam int CW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          clear = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  OP_t           cmd_op = NOP;
  logic [N-1:0]  cmd_data = '0;
  logic [CW-1:0] cmd_count = '0;
  logic          cmd_fill = 1'b0;
  OP_t           S;
  logic [N-1:0]  D;
  logic          MSBin, LSBin;
  logic [N-1:0]  sr_q;
  logic          busy, done;
  logic [N-1:0]  result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.N(N), .CW(CW)) dut (
    .clk(clk), .clear(clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count), .cmd_fill(cmd_fill),
    .S(S), .D(D), .MSBin(MSBin), .LSBin(LSBin),
    .sr_q(sr_q), .busy(busy), .done(done), .result(result)
  );

  shift_reg #(.N(N)) u_sr (
    .clk(clk), .clear(clear), .S(S), .D(D), .MSBin(MSBin), .LSBin(LSBin), .Q(sr_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected S after the j-th edge following the accept edge (j=0 is the accept edge).
  function automatic OP_t exp_s(input OP_t op, input int c, input int j);
    if (op == NOP) return NOP;
    if (j == 0) return IILOAD;
    if (op == IILOAD || c == 0) return NOP;
    if (j <= c) return op;
    return NOP;
  endfunction

  task automatic run(input string tag, input OP_t op, input logic [7:0] data,
                     input int c, input logic fill, input logic [7:0] exp_res,
                     input int exp_lat);
    int lat;
    logic seen;
    logic e_msb, e_lsb;
    lat  = 0;
    seen = 1'b0;
    @(negedge clk);
    chk({tag, ".rdy"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_count = CW'(c); cmd_fill = fill;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk({tag, ".S0"}, S, exp_s(op, c, 0));
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk); #1;
      e_msb = (op == LSR) && fill && (c > 0) && (j <= c);
      e_lsb = (op == LSL) && fill && (c > 0) && (j <= c);
      chk({tag, ".S"}, S, exp_s(op, c, j));
      chk({tag, ".msb"}, MSBin, e_msb);
      chk({tag, ".lsb"}, LSBin, e_lsb);
      if (done) begin
        lat  = j;
        seen = 1'b1;
        break;
      end
    end
    chk({tag, ".seen"}, seen, 1);
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".res"}, result, exp_res);
    chk({tag, ".q"}, sr_q, exp_res);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, done, 0);
    chk({tag, ".hold"}, result, exp_res);
  endtask

  initial begin
    logic seen;
    int   lat;

    // 1. reset at start
    clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.S", S, NOP);
    chk("rst.D", D, 0);
    chk("rst.done", done, 0);
    chk("rst.res", result, 0);
    chk("rst.q", sr_q, 0);
    @(negedge clk);
    clear = 1'b1;
    #1;
    chk("rst.rdy", cmd_ready, 1);
    chk("rst.busy", busy, 0);

    // 2. LSR 0110_0001 >>3 fill 1
    run("lsr", LSR, 8'b0110_0001, 3, 1'b1, 8'b1110_1100, 5);
    // 3. RL full turn and one past
    run("rl8", RL, 8'b0001_1011, 8, 1'b0, 8'b0001_1011, 10);
    run("rl9", RL, 8'b0001_1011, 9, 1'b0, 8'b0011_0110, 11);
    // 4. ASR, then NOP on the resulting Q, then ASL by 0
    run("asr", ASR, 8'b1011_0011, 2, 1'b0, 8'b1110_1100, 4);
    // 5. NOP reports current Q without touching the register
    run("nop", NOP, 8'b0101_0101, 3, 1'b1, 8'b1110_1100, 1);
    run("asl0", ASL, 8'b0010_1101, 0, 1'b0, 8'b0010_1101, 2);
    run("ild", IILOAD, 8'b1010_0101, 5, 1'b1, 8'b1010_0101, 2);

    // 6a. command held while busy: accepted on the done cycle
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = RR; cmd_data = 8'b1000_0001; cmd_count = CW'(2); cmd_fill = 1'b0;
    @(posedge clk); #1;
    cmd_op = LSL; cmd_data = 8'b1001_0101; cmd_count = CW'(1); cmd_fill = 1'b1;
    seen = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        chk("fc.res1", result, 8'b0110_0000);
        chk("fc.rdy_done", cmd_ready, 1);
        break;
      end
      chk("fc.rdy_busy", cmd_ready, 0);
    end
    chk("fc.seen1", seen, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("fc.acc", S, IILOAD);
    chk("fc.pulse", done, 0);
    seen = 1'b0;
    lat  = 0;
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        lat  = j;
        break;
      end
    end
    chk("fc.seen2", seen, 1);
    chk("fc.lat2", lat, 3);
    chk("fc.res2", result, 8'b0010_1011);

    // 6b. clear during SHIFT drops the command
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = ASR; cmd_data = 8'b1111_0000; cmd_count = CW'(6); cmd_fill = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("clr.inshift", S, ASR);
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("clr.S", S, NOP);
    chk("clr.D", D, 0);
    chk("clr.q", sr_q, 0);
    chk("clr.res", result, 0);
    chk("clr.rdy", cmd_ready, 1);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      chk("clr.nodone", done, 0);
    end
    @(negedge clk);
    clear = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      chk("clr.after", done, 0);
    end
    run("post", RR, 8'b0001_1011, 9, 1'b0, 8'b1000_1101, 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Upstream command sequencer for the 8-op shift register (NOP/IILOAD/LSR/LSL/RR/RL/ASR/ASL).
- Accepts one command per valid/ready handshake: op, load data, shift count, serial fill bit.
- Drives the register's S/D/MSBin/LSBin for exactly the required cycles.
- Reads back the register output and returns it with a one-cycle done pulse.

Parameters:
- N, 8: register width; must match the shift register.
- CW, $clog2(N)+1: shift-count width; allows 0..2N-1 shifts.

Ports:
- clk  in  1  clock, rising edge.
- clear  in  1  asynchronous active-low reset; same net as the shift register's clear.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  3  OP_t operation.
- cmd_data  in  N  value loaded before shifting.
- cmd_count  in  CW  number of shift cycles.
- cmd_fill  in  1  serial-in bit (MSBin for LSR, LSBin for LSL).
- S  out  3  op select to shift register.
- D  out  N  parallel data to shift register.
- MSBin  out  1  to shift register.
- LSBin  out  1  to shift register.
- sr_q  in  N  shift register Q.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse, result valid.
- result  out  N  sr_q captured at completion; holds until the next done.

Behaviour:
- All outputs registered except cmd_ready and busy (decoded from state).
- Reset (clear low, async): state=IDLE, S=NOP, D=0, MSBin=0, LSBin=0, done=0, result=0, remaining=0.
- States IDLE, LOAD, SHIFT, DONE (enum).
- Accept occurs on a rising edge with cmd_valid && cmd_ready; latch op, count, fill.

IDLE:
- On accept with op=NOP -> DONE, S=NOP.
- On accept with any other op -> LOAD, S=IILOAD, D=cmd_data.
- Otherwise S=NOP.

LOAD (one cycle, the register loads D on this edge):
- If op=IILOAD or count=0 -> DONE, S=NOP.
- Else -> SHIFT with S=op, remaining=count.
- MSBin=fill if op=LSR, else 0. LSBin=fill if op=LSL, else 0.

SHIFT:
- Each edge: remaining-=1.
- On the edge where remaining==1 -> DONE, S=NOP, MSBin=LSBin=0.

DONE (one cycle, sr_q now final):
- Next edge -> IDLE, done=1, result=sr_q.

done:
- Deasserts after exactly one cycle.
- A new command may be accepted in the same cycle done is high.

Latency (accept on edge k, count c):
- c>0: shifts occur on edges k+2..k+1+c; done visible after edge k+2+c.
- c=0 or IILOAD: done after edge k+2.
- NOP: done after edge k+1; result = current sr_q, register untouched.

Boundary rules:
- count>N is legal; performs that many shifts (e.g. RR by N+1 equals RR by 1).
- cmd_valid while busy: ignored (ready=0); command must stay stable until accepted.
- clear low mid-operation: immediate return to reset values; no done pulse; the in-flight command is lost.
- D holds its last loaded value outside LOAD; the register ignores D for all ops except IILOAD.

Decomposition:
- Package shift_pkg:
  - OP_t enum logic[2:0] {NOP, IILOAD, LSR, LSL, RR, RL, ASR, ASL}.
  - seq_state_t enum.
  - Default width constant 8.
- The shift register and the bench import OP_t from shift_pkg instead of redeclaring it.
- No sub-module: FSM plus CW-bit down-counter in one module.
- Integration wrapper (bench-side) instantiates shift_seq_ctrl feeding the shift register, with sr_q tied to Q.

Test Plan (N=8, all with the shift register connected):
1. Reset: clear low for 3 cycles, mid-operation and at start -> S=000, D=0, done=0, result=0, cmd_ready=1 after release; register Q=0.
2. LSR, data 0110_0001, count 3, fill 1 -> done exactly 5 edges after accept, result 1110_1100; MSBin=1 only during SHIFT.
3. RL, data 0001_1011, count 8 -> result 0001_1011, done 10 edges after accept. Repeat with count 9 -> result 0011_0110.
4. ASR, data 1011_0011, count 2 -> result 1110_1100. Then ASL, data 0010_1101, count 0 -> result 0010_1101, done 2 edges after accept.
5. NOP accepted with Q=1110_1100 -> done 1 edge later, result 1110_1100, S never leaves 000.
6. Flow control:
   - Hold cmd_valid with LSL, data 1001_0101, count 1, fill 1 while busy -> not accepted until the done cycle, then back-to-back result 0010_1011.
   - Assert clear during SHIFT of another command -> no done; next command completes normally.
